gray_ptr_ctrl: RTL
==================

GRAY_PTR_CTRL -- requirements
Module: gray_ptr_ctrl

Interface
REQ-001 Parameter: DEPTH, default 8, number of storage entries; SHALL be a power of two, at least 2.
REQ-002 Parameter: AFULL, default 6, occupancy at or above which almost_full asserts; range 1..DEPTH.
REQ-003 Derived constant: ADDR = log2(DEPTH); pointers SHALL be ADDR+1 bits wide (extra wrap bit).
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 clear  input  1  synchronous flush of both pointers.
REQ-007 wr_req  input  1  write request.
REQ-008 rd_req  input  1  read request.
REQ-009 wr_ack  output  1  write accepted this cycle.
REQ-010 rd_ack  output  1  read accepted this cycle.
REQ-011 waddr  output  ADDR  storage write address (low bits of write pointer).
REQ-012 raddr  output  ADDR  storage read address (low bits of read pointer).
REQ-013 wptr_gray  output  ADDR+1  registered Gray code of the write pointer.
REQ-014 rptr_gray  output  ADDR+1  registered Gray code of the read pointer.
REQ-015 full, empty, almost_full  output  1 each  status flags.
REQ-016 count  output  ADDR+1  current occupancy, 0..DEPTH.
REQ-017 ovf, udf  output  1 each  sticky overflow and underflow error flags.

Function
REQ-018 wr_ack SHALL equal wr_req & ~full & ~clear, combinationally from registered state.
REQ-019 rd_ack SHALL equal rd_req & ~empty & ~clear, combinationally from registered state.
REQ-020 On wr_ack, the binary write pointer SHALL increment by 1 modulo 2^(ADDR+1) at the next edge.
REQ-021 On rd_ack, the binary read pointer SHALL increment by 1 modulo 2^(ADDR+1) at the next edge.
REQ-022 empty SHALL assert exactly when the write and read pointers are equal.
REQ-023 full SHALL assert exactly when the MSBs of the two pointers differ and the low ADDR bits match.
REQ-024 count SHALL equal the write pointer minus the read pointer, in ADDR+1-bit modular arithmetic.
REQ-025 almost_full SHALL assert when count >= AFULL.
REQ-026 wptr_gray and rptr_gray SHALL be registered from the Gray code of the next-state pointers, so they change on the same edge as the binary pointers and carry no combinational glitch.
REQ-027 Each Gray pointer SHALL change in exactly one bit per increment, including on wrap from 2^(ADDR+1)-1 to 0.
REQ-028 Simultaneous write and read while full: the read is accepted, the write is rejected, and the result is count DEPTH-1.
REQ-029 Simultaneous write and read while empty: the write is accepted, the read is rejected, and the result is count 1.
REQ-030 Simultaneous write and read otherwise: both are accepted and count is unchanged.
REQ-031 wr_req while full SHALL set ovf; rd_req while empty SHALL set udf. Both flags SHALL remain set until reset or clear.
REQ-032 clear SHALL take priority over requests. At the next edge it SHALL zero both pointers, both Gray pointers, ovf and udf.

Reset
REQ-033 While reset is high, regardless of clk: both pointers and both Gray pointers SHALL be 0, ovf and udf SHALL be 0, empty SHALL be 1, and full, almost_full and count SHALL be 0.
REQ-034 A reset asserted mid-operation SHALL discard all occupancy immediately, and no ack SHALL be issued while reset is high.
REQ-035 Deassertion of reset SHALL require no specific alignment; the first accepted request can occur on the first edge after release.

Structure
REQ-036 No new typedefs are introduced; ADDR SHALL be derived locally from DEPTH.
REQ-037 Gray conversion SHALL reuse the existing bin_gray sub-module, one instance per pointer, applied to the next-state pointer.
REQ-038 The pointer counters SHALL be local registers. The existing synchronous-reset counter SHALL NOT be used, because this block requires asynchronous reset.

Verification
REQ-039 DEPTH=4, AFULL=3: four writes from reset -> count steps 1,2,3,4; almost_full rises at count 3; full rises at count 4; wptr_gray ends at 3'b110.
REQ-040 When full, assert wr_req and rd_req together -> rd_ack=1, wr_ack=0, count=3, ovf stays 0.
REQ-041 From empty, assert wr_req and rd_req together -> wr_ack=1, rd_ack=0, count=1, udf stays 0.
REQ-042 Sixteen accepted write/read pairs -> Gray pointers change by exactly one bit on every increment, through wrap 3'b100 -> 3'b000, and empty holds throughout.
REQ-043 rd_req while empty -> udf=1 and sticky; then clear -> udf=0, pointers=0, empty=1.
REQ-044 Assert reset asynchronously mid-cycle with count=2 -> outputs reach reset values before the next clk edge.

Source files
------------

// File: rtl/gray_ptr_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : gray_ptr_ctrl_pkg                                          |
// | Purpose  : Shared constants and the binary-to-Gray helper used by     |
// |            the pointer controller and its Gray converter.             |
// | Ports    : none (package)                                             |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package gray_ptr_ctrl_pkg;

   localparam int c_default_depth = 8;
   localparam int c_default_afull = 6;

   // Reflected binary code: each increment flips exactly one bit, including
   // the wrap from all-ones back to zero.
   function automatic logic [31:0] to_gray(input logic [31:0] bin);
      return bin ^ (bin >> 1);
   endfunction

endpackage : gray_ptr_ctrl_pkg
`default_nettype wire

// File: rtl/gray_ptr_ctrl_bin_gray.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bin_gray                                                   |
// | Purpose  : Combinational binary-to-Gray converter.                    |
// | Ports    : bin_i  [WIDTH] binary input                                |
// |            gray_o [WIDTH] Gray-coded output                           |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module bin_gray
   import gray_ptr_ctrl_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] bin_i,
   output logic [WIDTH-1:0] gray_o
);

   logic [31:0] w_gray_wide;

   assign w_gray_wide = to_gray(32'(bin_i));
   assign gray_o      = w_gray_wide[WIDTH-1:0];

endmodule : bin_gray
`default_nettype wire

// File: rtl/gray_ptr_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : gray_ptr_ctrl                                              |
// | Purpose  : FIFO pointer controller with binary pointers carrying an   |
// |            extra wrap bit, registered Gray copies for CDC, occupancy  |
// |            count, status flags and sticky overflow/underflow flags.   |
// | Ports    : clk, reset (async, active-high), clear (sync flush)        |
// |            wr_req/rd_req  -> wr_ack/rd_ack                            |
// |            waddr/raddr [ADDR]       storage addresses                 |
// |            wptr_gray/rptr_gray [ADDR+1] registered Gray pointers      |
// |            full, empty, almost_full, count [ADDR+1], ovf, udf         |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module gray_ptr_ctrl
   import gray_ptr_ctrl_pkg::*;
#(
   parameter  int DEPTH = c_default_depth,
   parameter  int AFULL = c_default_afull,
   localparam int ADDR  = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clear,
   input  logic            wr_req,
   input  logic            rd_req,
   output logic            wr_ack,
   output logic            rd_ack,
   output logic [ADDR-1:0] waddr,
   output logic [ADDR-1:0] raddr,
   output logic [ADDR:0]   wptr_gray,
   output logic [ADDR:0]   rptr_gray,
   output logic            full,
   output logic            empty,
   output logic            almost_full,
   output logic [ADDR:0]   count,
   output logic            ovf,
   output logic            udf
);

   localparam logic [ADDR:0] c_afull = (ADDR+1)'(AFULL);
   localparam logic [ADDR:0] c_one   = (ADDR+1)'(1);

   logic [ADDR:0] wptr_q, wptr_d;
   logic [ADDR:0] rptr_q, rptr_d;
   logic [ADDR:0] wgray_q, wgray_d;
   logic [ADDR:0] rgray_q, rgray_d;
   logic          ovf_q, ovf_d;
   logic          udf_q, udf_d;
   logic          w_full, w_empty;

   assign w_empty = (wptr_q == rptr_q);
   assign w_full  = (wptr_q[ADDR] != rptr_q[ADDR]) &&
                    (wptr_q[ADDR-1:0] == rptr_q[ADDR-1:0]);

   // Acks are gated by reset as well, since during reset the flags show
   // "empty, not full" and a write would otherwise look acceptable.
   assign wr_ack = wr_req & ~w_full  & ~clear & ~reset;
   assign rd_ack = rd_req & ~w_empty & ~clear & ~reset;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      ovf_d  = ovf_q;
      udf_d  = udf_q;
      if (clear) begin
         wptr_d = '0;
         rptr_d = '0;
         ovf_d  = 1'b0;
         udf_d  = 1'b0;
      end else begin
         if (wr_ack) wptr_d = wptr_q + c_one;
         if (rd_ack) rptr_d = rptr_q + c_one;
         // A rejected write paired with an accepted read (or the reverse)
         // is the defined full/empty collision behaviour, not an error.
         if (wr_req && w_full && !rd_req)   ovf_d = 1'b1;
         if (rd_req && w_empty && !wr_req)  udf_d = 1'b1;
      end
   end

   // Gray codes are taken from the next-state pointers so the registered
   // Gray value moves on the same edge as the binary pointer.
   bin_gray #(.WIDTH(ADDR+1)) u_wgray (.bin_i(wptr_d), .gray_o(wgray_d));
   bin_gray #(.WIDTH(ADDR+1)) u_rgray (.bin_i(rptr_d), .gray_o(rgray_d));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         wgray_q <= '0;
         rgray_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         wgray_q <= wgray_d;
         rgray_q <= rgray_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   assign waddr       = wptr_q[ADDR-1:0];
   assign raddr       = rptr_q[ADDR-1:0];
   assign wptr_gray   = wgray_q;
   assign rptr_gray   = rgray_q;
   assign full        = w_full;
   assign empty       = w_empty;
   assign count       = wptr_q - rptr_q;
   assign almost_full = (count >= c_afull);
   assign ovf         = ovf_q;
   assign udf         = udf_q;

endmodule : gray_ptr_ctrl
`default_nettype wire
